// File: rtl/spu32_mem16_ctrl_if.sv
// Bus bundle between the two 32-bit requesters, the shared 16-bit tagged
// SRAM port and the spu32_mem16_ctrl arbiter. Directions in the slave
// modport are as seen by the controller.
interface spu32_mem16_ctrl_if #(
    parameter int SRAM_ADDR_BITS = 18
);
    logic                      I_rq0_stb;
    logic                      I_rq0_we;
    logic [SRAM_ADDR_BITS:0]   I_rq0_addr;
    logic [3:0]                I_rq0_sel;
    logic [31:0]               I_rq0_data;
    logic [31:0]               O_rq0_data;
    logic                      O_rq0_ack;

    logic                      I_rq1_stb;
    logic                      I_rq1_we;
    logic [SRAM_ADDR_BITS:0]   I_rq1_addr;
    logic [3:0]                I_rq1_sel;
    logic [31:0]               I_rq1_data;
    logic [31:0]               O_rq1_data;
    logic                      O_rq1_ack;

    logic [3:0]                O_mem_request;
    logic                      O_mem_we;
    logic                      O_mem_ub;
    logic                      O_mem_lb;
    logic [SRAM_ADDR_BITS-1:0] O_mem_addr;
    logic [15:0]               O_mem_data;
    logic [15:0]               I_mem_data;
    logic [3:0]                I_mem_ack;
    logic                      I_mem_stall;

    // controller side
    modport slave (
        input  I_rq0_stb, I_rq0_we, I_rq0_addr, I_rq0_sel, I_rq0_data,
        output O_rq0_data, O_rq0_ack,
        input  I_rq1_stb, I_rq1_we, I_rq1_addr, I_rq1_sel, I_rq1_data,
        output O_rq1_data, O_rq1_ack,
        output O_mem_request, O_mem_we, O_mem_ub, O_mem_lb, O_mem_addr, O_mem_data,
        input  I_mem_data, I_mem_ack, I_mem_stall
    );

    // requester and memory side
    modport master (
        output I_rq0_stb, I_rq0_we, I_rq0_addr, I_rq0_sel, I_rq0_data,
        input  O_rq0_data, O_rq0_ack,
        output I_rq1_stb, I_rq1_we, I_rq1_addr, I_rq1_sel, I_rq1_data,
        input  O_rq1_data, O_rq1_ack,
        input  O_mem_request, O_mem_we, O_mem_ub, O_mem_lb, O_mem_addr, O_mem_data,
        output I_mem_data, I_mem_ack, I_mem_stall
    );
endinterface

// File: rtl/spu32_mem16_ctrl.sv
// Shares one 16-bit tagged SRAM port between an instruction-fetch port (0)
// and a data port (1). Each 32-bit request is split into low/high half
// accesses; read halves are reassembled before the requester is acked.
module spu32_mem16_ctrl #(
    parameter int SRAM_ADDR_BITS = 18
) (
    input  logic I_clk,
    input  logic I_reset_n,
    spu32_mem16_ctrl_if.slave bus
);
    localparam int AW = SRAM_ADDR_BITS;

    typedef enum logic [2:0] {IDLE, ISSUE_LO, ISSUE_HI, WAIT, DONE} state_t;

    state_t        state, state_d;
    logic          port_q, last_q;
    logic          grant, grant_port;
    logic          we_q;
    logic [AW-2:0] waddr_q;
    logic [3:0]    sel_q;
    logic [31:0]   data_q, result_q, result_d;
    logic [3:0]    mask_q, mask_d, mask_left, ack_hit;
    logic          need_lo, need_hi;
    logic [3:0]    tag_lo, tag_hi;
    logic [3:0]    mem_req;
    logic          mem_we, mem_ub, mem_lb;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data;
    logic          rq0_ack_q, rq1_ack_q;
    logic [31:0]   rq0_data_q, rq1_data_q;
    logic          unused_addr_lsbs;

    // Word-aligned access: the byte lane bits of the address carry no meaning.
    assign unused_addr_lsbs = ^{bus.I_rq0_addr[1:0], bus.I_rq1_addr[1:0]};

    assign need_lo   = !we_q || (sel_q[1:0] != 2'b00);
    assign need_hi   = !we_q || (sel_q[3:2] != 2'b00);
    assign tag_lo    = port_q ? 4'b0100 : 4'b0001;
    assign tag_hi    = port_q ? 4'b1000 : 4'b0010;
    assign ack_hit   = bus.I_mem_ack & mask_q;
    assign mask_left = mask_q & ~bus.I_mem_ack;

    // Merge returning read halves into the word being assembled.
    always_comb begin
        result_d = result_q;
        if (!we_q && ((ack_hit & 4'b0101) != 4'b0000)) result_d[15:0]  = bus.I_mem_data;
        if (!we_q && ((ack_hit & 4'b1010) != 4'b0000)) result_d[31:16] = bus.I_mem_data;
    end

    // Arbitration, half-access sequencing and memory-port drive.
    always_comb begin
        state_d    = state;
        mask_d     = mask_left;
        grant      = 1'b0;
        grant_port = port_q;
        mem_req    = 4'b0000;
        mem_we     = 1'b0;
        mem_ub     = 1'b0;
        mem_lb     = 1'b0;
        mem_addr   = '0;
        mem_data   = 16'h0000;
        case (state)
            IDLE: begin
                // last_q=1 means port 1 won last time, so port 0 wins a tie.
                if (bus.I_rq0_stb && (!bus.I_rq1_stb || last_q)) begin
                    grant      = 1'b1;
                    grant_port = 1'b0;
                    state_d    = ISSUE_LO;
                end else if (bus.I_rq1_stb) begin
                    grant      = 1'b1;
                    grant_port = 1'b1;
                    state_d    = ISSUE_LO;
                end
            end
            ISSUE_LO: begin
                if (we_q && (sel_q == 4'b0000)) begin
                    state_d = DONE;
                end else if (!need_lo) begin
                    state_d = ISSUE_HI;
                end else if (!bus.I_mem_stall) begin
                    mem_req  = tag_lo;
                    mem_we   = we_q;
                    mem_ub   = we_q ? sel_q[1] : 1'b1;
                    mem_lb   = we_q ? sel_q[0] : 1'b1;
                    mem_addr = {waddr_q, 1'b0};
                    mem_data = data_q[15:0];
                    mask_d   = mask_left | tag_lo;
                    state_d  = ISSUE_HI;
                end
            end
            ISSUE_HI: begin
                if (!need_hi) begin
                    state_d = WAIT;
                end else if (!bus.I_mem_stall) begin
                    mem_req  = tag_hi;
                    mem_we   = we_q;
                    mem_ub   = we_q ? sel_q[3] : 1'b1;
                    mem_lb   = we_q ? sel_q[2] : 1'b1;
                    mem_addr = {waddr_q, 1'b1};
                    mem_data = data_q[31:16];
                    mask_d   = mask_left | tag_hi;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                // Acks landing this cycle count, so the last half costs no extra cycle.
                if (mask_left == 4'b0000) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.O_mem_request = mem_req;
    assign bus.O_mem_we      = mem_we;
    assign bus.O_mem_ub      = mem_ub;
    assign bus.O_mem_lb      = mem_lb;
    assign bus.O_mem_addr    = mem_addr;
    assign bus.O_mem_data    = mem_data;
    assign bus.O_rq0_ack     = rq0_ack_q;
    assign bus.O_rq1_ack     = rq1_ack_q;
    assign bus.O_rq0_data    = rq0_data_q;
    assign bus.O_rq1_data    = rq1_data_q;

    // Control state, pending-ack mask and registered completion outputs.
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state      <= IDLE;
            port_q     <= 1'b0;
            last_q     <= 1'b1;
            mask_q     <= 4'b0000;
            rq0_ack_q  <= 1'b0;
            rq1_ack_q  <= 1'b0;
            rq0_data_q <= 32'h0;
            rq1_data_q <= 32'h0;
        end else begin
            state     <= state_d;
            mask_q    <= mask_d;
            rq0_ack_q <= (state_d == DONE) && !port_q;
            rq1_ack_q <= (state_d == DONE) && port_q;
            if (grant) begin
                port_q <= grant_port;
                last_q <= grant_port;
            end
            if ((state_d == DONE) && !port_q) rq0_data_q <= we_q ? 32'h0 : result_d;
            if ((state_d == DONE) && port_q)  rq1_data_q <= we_q ? 32'h0 : result_d;
        end
    end

    // Latched request fields and the read-assembly buffer.
    always_ff @(posedge I_clk) begin
        result_q <= result_d;
        if (grant) begin
            we_q    <= grant_port ? bus.I_rq1_we : bus.I_rq0_we;
            waddr_q <= grant_port ? bus.I_rq1_addr[AW:2] : bus.I_rq0_addr[AW:2];
            sel_q   <= grant_port ? bus.I_rq1_sel : bus.I_rq0_sel;
            data_q  <= grant_port ? bus.I_rq1_data : bus.I_rq0_data;
        end
    end
endmodule

// File: tb/tb_spu32_mem16_ctrl.sv
// Randomized bench for spu32_mem16_ctrl: a word-level reference memory and
// a slot/stall timing model predict each completion; a tagged SRAM responder
// answers the DUT's half accesses one cycle after issue.
module tb_spu32_mem16_ctrl;
    localparam int AB = 18;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spu32_mem16_ctrl_if #(.SRAM_ADDR_BITS(AB)) bus ();
    spu32_mem16_ctrl #(.SRAM_ADDR_BITS(AB)) dut (.I_clk(clk), .I_reset_n(rst_n), .bus(bus));

    logic        stb   [2];
    logic        we    [2];
    logic [AB:0] addr  [2];
    logic [3:0]  sel   [2];
    logic [31:0] wdata [2];
    logic        stall = 1'b0;
    logic [3:0]  inject = 4'h0;
    logic [3:0]  mack = 4'h0;
    logic [15:0] mdata = 16'h0;

    assign bus.I_rq0_stb  = stb[0];
    assign bus.I_rq0_we   = we[0];
    assign bus.I_rq0_addr = addr[0];
    assign bus.I_rq0_sel  = sel[0];
    assign bus.I_rq0_data = wdata[0];
    assign bus.I_rq1_stb  = stb[1];
    assign bus.I_rq1_we   = we[1];
    assign bus.I_rq1_addr = addr[1];
    assign bus.I_rq1_sel  = sel[1];
    assign bus.I_rq1_data = wdata[1];
    assign bus.I_mem_stall = stall;
    assign bus.I_mem_ack   = mack;
    assign bus.I_mem_data  = mdata;

    typedef struct {
        logic [3:0]    tag;
        logic [AB-1:0] a;
        logic [15:0]   d;
        logic          w, ub, lb;
        int            c;
    } req_t;

    logic [15:0] sram    [0:511];
    logic [31:0] ref_mem [0:255];
    logic [31:0] hold    [2];
    logic        stall_pat [0:47];
    req_t        obs_q [$];
    logic [3:0]  pend_tag = 4'h0;
    logic [15:0] pend_data = 16'h0;
    bit          bus_bad = 1'b0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          rr_last;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM responder: echoes last cycle's tag with its read data.
    always @(negedge clk) begin
        req_t r;
        int   idx;
        mack  = pend_tag | inject;
        mdata = (pend_tag != 4'h0) ? pend_data : 16'($urandom);
        pend_tag = 4'h0;
        if (bus.O_mem_request != 4'h0) begin
            if (!$onehot(bus.O_mem_request)) bus_bad = 1'b1;
            r.tag = bus.O_mem_request; r.a = bus.O_mem_addr; r.d = bus.O_mem_data;
            r.w = bus.O_mem_we; r.ub = bus.O_mem_ub; r.lb = bus.O_mem_lb; r.c = cyc;
            obs_q.push_back(r);
            idx = int'(bus.O_mem_addr[8:0]);
            if (bus.O_mem_we) begin
                if (bus.O_mem_ub) sram[idx][15:8] = bus.O_mem_data[15:8];
                if (bus.O_mem_lb) sram[idx][7:0]  = bus.O_mem_data[7:0];
            end else begin
                pend_data = sram[idx];
            end
            pend_tag = bus.O_mem_request;
        end else if (bus.O_mem_we || bus.O_mem_ub || bus.O_mem_lb ||
                     bus.O_mem_addr != '0 || bus.O_mem_data != 16'h0) begin
            bus_bad = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic ackof(input int p);
        return (p != 0) ? bus.O_rq1_ack : bus.O_rq0_ack;
    endfunction

    function automatic logic [31:0] dataof(input int p);
        return (p != 0) ? bus.O_rq1_data : bus.O_rq0_data;
    endfunction

    task automatic clear_stall();
        for (int i = 0; i < 48; i++) stall_pat[i] = 1'b0;
    endtask

    task automatic rand_stall();
        clear_stall();
        for (int i = 1; i < 16; i++) stall_pat[i] = ($urandom_range(0, 3) == 0);
    endtask

    task automatic start(input int p, input logic w, input logic [AB:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        we[p] = w; addr[p] = a; sel[p] = s; wdata[p] = d; stb[p] = 1'b1;
    endtask

    // Called in the cycle where port p's strobe is seen by an idle arbiter.
    task automatic do_txn(input int p);
        req_t        e [2];
        int          nexp, exp_done, got_t, t, cyc0, widx;
        bit          nlo, nhi, other;
        logic [31:0] exp_data;
        widx = int'(addr[p][9:2]);
        nlo  = !we[p] || (sel[p][1:0] != 2'b00);
        nhi  = !we[p] || (sel[p][3:2] != 2'b00);
        nexp = 0;
        if (we[p] && sel[p] == 4'h0) begin
            exp_done = 2;
        end else begin
            t = 1;
            for (int h = 0; h < 2; h++) begin
                if (h == 0 ? nlo : nhi) begin
                    while (stall_pat[t]) t++;
                    e[nexp].tag = 4'(1 << (2 * p + h));
                    e[nexp].a   = AB'((int'(addr[p]) >> 2) * 2 + h);
                    e[nexp].d   = (h == 0) ? wdata[p][15:0] : wdata[p][31:16];
                    e[nexp].w   = we[p];
                    e[nexp].ub  = we[p] ? sel[p][2 * h + 1] : 1'b1;
                    e[nexp].lb  = we[p] ? sel[p][2 * h] : 1'b1;
                    e[nexp].c   = t;
                    nexp++;
                end
                if (h == 0) t++;
            end
            exp_done = t + 2;
        end
        exp_data = we[p] ? 32'h0 : ref_mem[widx];
        if (we[p])
            for (int b = 0; b < 4; b++)
                if (sel[p][b]) ref_mem[widx][8 * b +: 8] = wdata[p][8 * b +: 8];

        cyc0 = cyc;
        obs_q.delete();
        got_t = -1;
        other = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            stall = stall_pat[c];
            if (ackof(p)) begin got_t = c; break; end
            if (ackof(1 - p)) other = 1'b1;
        end
        stall = 1'b0;
        check($sformatf("latency p%0d", p), 64'(got_t), 64'(exp_done));
        if (got_t > 0) check($sformatf("rdata p%0d", p), 64'(dataof(p)), 64'(exp_data));
        check("other_ack", 64'(other), 64'h0);
        stb[p] = 1'b0;
        hold[p] = exp_data;
        rr_last = p;
        @(posedge clk); #1;
        check("ack_pulse", 64'(ackof(p)), 64'h0);
        check("hold_other", 64'(dataof(1 - p)), 64'(hold[1 - p]));
        check("nreq", 64'(obs_q.size()), 64'(nexp));
        for (int i = 0; i < nexp && i < obs_q.size(); i++) begin
            check("req_tag", 64'(obs_q[i].tag), 64'(e[i].tag));
            check("req_addr", 64'(obs_q[i].a), 64'(e[i].a));
            check("req_cycle", 64'(obs_q[i].c - cyc0), 64'(e[i].c));
            check("req_we", 64'(obs_q[i].w), 64'(e[i].w));
            check("req_ublb", 64'({obs_q[i].ub, obs_q[i].lb}), 64'({e[i].ub, e[i].lb}));
            if (e[i].w) check("req_wdata", 64'(obs_q[i].d), 64'(e[i].d));
        end
    endtask

    task automatic rand_fields(input int p);
        logic w;
        w = 1'($urandom_range(0, 1));
        start(p, w, (AB + 1)'($urandom_range(0, 1023)),
              ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15)), $urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        for (int p = 0; p < 2; p++) begin
            stb[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; sel[p] = 4'h0; wdata[p] = 32'h0;
            hold[p] = 32'h0;
        end
        for (int i = 0; i < 512; i++) sram[i] = 16'($urandom);
        sram[8] = 16'h5678;
        sram[9] = 16'h1234;
        for (int i = 0; i < 256; i++) ref_mem[i] = {sram[2 * i + 1], sram[2 * i]};
        rr_last = 1;
        clear_stall();

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack0", 64'(bus.O_rq0_ack), 64'h0);
        check("rst_ack1", 64'(bus.O_rq1_ack), 64'h0);
        check("rst_data0", 64'(bus.O_rq0_data), 64'h0);
        check("rst_data1", 64'(bus.O_rq1_data), 64'h0);
        check("rst_req", 64'(bus.O_mem_request), 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // read reassembly on port 0
        start(0, 1'b0, 19'h00010, 4'h0, 32'h0);
        do_txn(0);
        // high-half-only write on port 1
        start(1, 1'b1, 19'h00004, 4'b1100, 32'hAABBCCDD);
        do_txn(1);
        // contention, twice
        for (int k = 0; k < 2; k++) begin
            start(0, 1'b0, 19'h00010, 4'h0, 32'h0);
            start(1, 1'b0, 19'h00004, 4'h0, 32'h0);
            w = (rr_last == 1) ? 0 : 1;
            do_txn(w);
            do_txn(1 - w);
        end
        // two stall cycles in the high-half slot
        stall_pat[2] = 1'b1; stall_pat[3] = 1'b1;
        start(0, 1'b0, 19'h00010, 4'h0, 32'h0);
        do_txn(0);
        clear_stall();
        // empty write, then a stray ack while idle
        start(1, 1'b1, 19'h00020, 4'h0, 32'h11223344);
        do_txn(1);
        inject = 4'b0100;
        @(posedge clk); #1;
        inject = 4'h0;
        @(posedge clk); #1;
        check("spur_ack1", 64'(bus.O_rq1_ack), 64'h0);
        check("spur_data1", 64'(bus.O_rq1_data), 64'(hold[1]));
        check("spur_req", 64'(bus.O_mem_request), 64'h0);

        // reset between low-half issue and its ack
        start(0, 1'b0, 19'h00040, 4'h0, 32'h0);
        @(posedge clk); #1;
        @(negedge clk); #1;
        rst_n = 1'b0;
        stb[0] = 1'b0;
        @(posedge clk); #1;
        check("midrst_req", 64'(bus.O_mem_request), 64'h0);
        rst_n = 1'b1;
        hold[0] = 32'h0; hold[1] = 32'h0; rr_last = 1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("midrst_noack", 64'({bus.O_rq0_ack, bus.O_rq1_ack}), 64'h0);
        end
        check("midrst_data0", 64'(bus.O_rq0_data), 64'h0);
        start(0, 1'b0, 19'h00040, 4'h0, 32'h0);
        do_txn(0);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                rand_fields(0);
                rand_fields(1);
                w = (rr_last == 1) ? 0 : 1;
                rand_stall();
                do_txn(w);
                rand_stall();
                do_txn(1 - w);
            end else begin
                w = int'($urandom_range(0, 1));
                rand_fields(w);
                rand_stall();
                do_txn(w);
            end
        end
        clear_stall();
        check("bus_idle_clean", 64'(bus_bad), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/spu32_mem16_ctrl.md
Name: spu32_mem16_ctrl

Overview:
Two-port controller that shares the 16-bit tagged SRAM port between port 0 (instruction fetch) and port 1 (data). Each port presents 32-bit byte-addressed requests. The block arbitrates round-robin between the ports and splits each word into low and high 16-bit half accesses. It respects the memory stall (VGA slot) and reassembles read data before acknowledging the requester.

Parameters:
SRAM_ADDR_BITS, 18, width of the 16-bit-word SRAM address. Byte address width is SRAM_ADDR_BITS+1.

Ports:
I_clk  in  1  clock; all state updates on the rising edge
I_reset_n  in  1  asynchronous active-low reset
I_rq0_stb / I_rq1_stb  in  1  request strobe; held by the requester until its ack
I_rq0_we / I_rq1_we  in  1  1 = write, 0 = read
I_rq0_addr / I_rq1_addr  in  SRAM_ADDR_BITS+1  byte address; bits [1:0] are ignored
I_rq0_sel / I_rq1_sel  in  4  byte enables; sel[0] selects bits [7:0], sel[3] selects bits [31:24]
I_rq0_data / I_rq1_data  in  32  write data
O_rq0_data / O_rq1_data  out  32  read data; valid while the matching ack is high
O_rq0_ack / O_rq1_ack  out  1  one-cycle completion pulse
O_mem_request  out  4  one-hot tag: bit0 = p0 low half, bit1 = p0 high, bit2 = p1 low, bit3 = p1 high
O_mem_we, O_mem_ub, O_mem_lb  out  1 each  memory control, valid with a nonzero request
O_mem_addr  out  SRAM_ADDR_BITS  half-word address
O_mem_data  out  16  write data
I_mem_data  in  16  read data; valid in the cycle the matching I_mem_ack is nonzero
I_mem_ack  in  4  echo of the tag, one cycle after issue
I_mem_stall  in  1  when 1, no request may be issued this cycle

Behaviour:
- Reset (async, I_reset_n=0):
  - state IDLE; round-robin pointer favours port 0.
  - All outputs 0; pending-ack mask cleared.
- States: IDLE -> ISSUE_LO -> ISSUE_HI -> WAIT -> DONE -> IDLE.
- IDLE arbitration:
  - Only one strobe high: grant that port.
  - Both high: grant the port not granted last.
  - Grant latches we, addr, sel, data and sets the pointer. Next state is ISSUE_LO.
- Half selection:
  - Reads always access both halves; sel is ignored.
  - Writes access the low half only if sel[1:0] != 0, and the high half only if sel[3:2] != 0.
  - A write with sel==0 goes straight to DONE with no memory access.
- ISSUE_LO / ISSUE_HI:
  - When the half is needed and I_mem_stall=0: drive O_mem_request = tag combinationally, set the expected-ack bit, advance.
  - When I_mem_stall=1: request 0, hold state.
  - A skipped half advances without issuing.
  - Low half: O_mem_addr = {addr[SRAM_ADDR_BITS:2],0}, O_mem_data = data[15:0], ub = sel[1], lb = sel[0].
  - High half: O_mem_addr = {addr[SRAM_ADDR_BITS:2],1}, O_mem_data = data[31:16], ub = sel[3], lb = sel[2].
  - O_mem_we = latched we. Reads drive ub = lb = 1.
  - When O_mem_request is 0, all other O_mem_* outputs are 0.
- Ack collection (any state):
  - An I_mem_ack bit matching an expected bit clears it.
  - On a read, I_mem_data is captured into result[15:0] (low tag) or result[31:16] (high tag).
  - Unexpected ack bits are ignored.
- WAIT: hold until the expected mask is 0, then go to DONE. If the mask is already 0 on entry, go to DONE on the next edge.
- DONE:
  - Registered ack of the granted port is 1 for exactly one cycle.
  - O_rqN_data = result; writes return 0.
  - Next state is IDLE. A strobe cannot be re-granted before IDLE, so there is no double-grant.
- O_rqN_data holds its value until the next completion on that port.
- Latency with no stall:
  - Read or full write: stb seen in cycle 0, requests in cycles 1 and 2, mem acks in cycles 2 and 3, ack in cycle 4.
  - Stall cycles add 1 each.
- Reset mid-operation aborts the transaction without acking. Memory acks arriving after reset are ignored because the mask is cleared.

Test Plan:
1. Read with stall=0: p0 addr 0x00010 → requests 4'b0001 at mem addr 0x00008, then 4'b0010 at 0x00009. Mem returns 0x5678, 0x1234 → O_rq0_data = 0x12345678, ack in cycle 4.
2. Write on p1, sel=4'b1100, data 0xAABBCCDD, addr 0x4 → single request 4'b1000 at mem addr 0x3, data 0xAABB, ub=lb=1, we=1 → O_rq1_ack one cycle after the mem ack.
3. Contention: both strobes high together, then again after the first completes → p0 granted first, then p1. Repeating the pattern grants alternate.
4. Stall: I_mem_stall high for 2 cycles during ISSUE_HI → O_mem_request stays 0 those cycles, high-half request follows, ack delayed by exactly 2 cycles.
5. Write with sel=0 → no nonzero O_mem_request; ack after 2 cycles. A spurious I_mem_ack=4'b0100 injected while idle changes nothing.
6. I_reset_n pulsed low between the low-half issue and its ack → no O_rq ack. The late mem ack is ignored, and the next request completes normally.
